// File: rtl/uart_cmd_seq.sv
// UART command sequencer: parses write (57,reg,data) and read (52,reg) frames,
// drives a simple register-bank bus and queues a one-byte response for the transmitter.
module uart_cmd_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [7:0]  ACK_BYTE    = 8'h4B,
    parameter logic [7:0]  ERR_BYTE    = 8'h45
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] uart_reg,
    output logic [7:0] uart_dbus_in,
    output logic       uart_dbus_w,
    output logic       uart_dbus_r,
    input  logic [7:0] uart_dbus_out,
    output logic       busy,
    output logic       cmd_err
);

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [2:0] {
        IDLE, GET_REG, GET_DATA, WRITE, READ, SEND
    } state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  txd_q, txd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        tmo;

    // Inter-byte timeout only matters while a frame is partially received
    assign tmo = (cnt_q == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            reg_q   <= 8'h00;
            din_q   <= 8'h00;
            txd_q   <= 8'h00;
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            reg_q   <= reg_d;
            din_q   <= din_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        reg_d       = reg_q;
        din_d       = din_q;
        txd_d       = txd_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        tx_start    = 1'b0;
        uart_dbus_w = 1'b0;
        uart_dbus_r = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        is_wr_d = (rx_data == OP_WR);
                        state_d = GET_REG;
                    end else begin
                        txd_d   = ERR_BYTE;
                        err_d   = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            GET_REG: begin
                if (rx_valid) begin
                    reg_d   = rx_data;
                    cnt_d   = 16'd0;
                    state_d = is_wr_q ? GET_DATA : READ;
                end else if (tmo) begin
                    cnt_d   = 16'd0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    din_d   = rx_data;
                    cnt_d   = 16'd0;
                    state_d = WRITE;
                end else if (tmo) begin
                    cnt_d   = 16'd0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WRITE: begin
                uart_dbus_w = 1'b1;
                txd_d       = ACK_BYTE;
                state_d     = SEND;
            end
            READ: begin
                uart_dbus_r = 1'b1;
                txd_d       = uart_dbus_out;
                state_d     = SEND;
            end
            SEND: begin
                // Hold the response until the transmitter can take it
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data      = txd_q;
    assign uart_reg     = reg_q;
    assign uart_dbus_in = din_q;
    assign busy         = (state_q != IDLE);
    assign cmd_err      = err_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Scoreboard bench for uart_cmd_seq: expected bus/response events are queued
// as frames are driven and retired by a monitor as the DUT produces them.
module tb_uart_cmd_seq;

    localparam logic [1:0] K_W = 2'd0, K_R = 2'd1, K_E = 2'd2, K_T = 2'd3;

    typedef struct packed {
        logic [1:0] k;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] uart_reg;
    logic [7:0] uart_dbus_in;
    logic       uart_dbus_w;
    logic       uart_dbus_r;
    logic [7:0] uart_dbus_out;
    logic       busy;
    logic       cmd_err;

    int total = 0;
    int bad   = 0;
    int tx_cnt = 0;
    ev_t q[$];
    logic [7:0] bank [256];

    always #5 sysclk = ~sysclk;

    uart_cmd_seq #(.TIMEOUT_CYC(16'd16), .ACK_BYTE(8'h4B), .ERR_BYTE(8'h45)) dut (
        .sysclk(sysclk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .uart_reg(uart_reg), .uart_dbus_in(uart_dbus_in), .uart_dbus_w(uart_dbus_w),
        .uart_dbus_r(uart_dbus_r), .uart_dbus_out(uart_dbus_out), .busy(busy),
        .cmd_err(cmd_err)
    );

    assign uart_dbus_out = bank[uart_reg];

    always @(posedge sysclk) if (uart_dbus_w && !reset) bank[uart_reg] <= uart_dbus_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [1:0] k, input logic [7:0] a,
                           input logic [7:0] d, input bit use_a, input bit use_d);
        ev_t e;
        if (q.size() == 0) begin
            chk({tag, "_unexpected"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_kind"}, k, e.k);
            if (use_a) chk({tag, "_reg"}, a, e.a);
            if (use_d) chk({tag, "_data"}, d, e.d);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge sysclk) begin
        if (!reset) begin
            chk("w_r_excl", {31'd0, uart_dbus_w & uart_dbus_r}, 0);
            if (uart_dbus_w) pop_chk("wr", K_W, uart_reg, uart_dbus_in, 1, 1);
            if (uart_dbus_r) pop_chk("rd", K_R, uart_reg, 8'h00, 1, 0);
            if (cmd_err)     pop_chk("err", K_E, 8'h00, 8'h00, 0, 0);
            if (tx_start) begin
                tx_cnt++;
                pop_chk("tx", K_T, 8'h00, tx_data, 0, 1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge sysclk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sysclk);
        rx_valid = 1'b0;
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.k = k; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    task automatic do_write(input logic [7:0] r, input logic [7:0] d);
        push(K_W, r, d);
        push(K_T, 8'h00, 8'h4B);
        send_byte(8'h57); send_byte(r); send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] r);
        push(K_R, r, 8'h00);
        push(K_T, 8'h00, bank[r]);
        send_byte(8'h52); send_byte(r);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(negedge sysclk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, n < 300}, 1);
        repeat (3) @(negedge sysclk);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int tx0;
        for (int i = 0; i < 256; i++) bank[i] = 8'(i) ^ 8'h5C;
        bank[4] = 8'hAA;

        repeat (3) @(negedge sysclk);
        chk("rst_busy", busy, 0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_reg", uart_reg, 8'h00);
        chk("rst_din", uart_dbus_in, 8'h00);
        chk("rst_strobes", {tx_start, uart_dbus_w, uart_dbus_r, cmd_err}, 0);
        reset = 1'b0;
        @(negedge sysclk);

        do_write(8'h02, 8'h5A);
        wait_idle("write");
        chk("hold_reg", uart_reg, 8'h02);
        chk("hold_din", uart_dbus_in, 8'h5A);

        do_read(8'h04);
        wait_idle("read");
        do_read(8'h02);
        wait_idle("read_back");
        do_read(8'hFF);
        wait_idle("read_ff");

        push(K_E, 8'h00, 8'h00);
        push(K_T, 8'h00, 8'h45);
        send_byte(8'h33);
        wait_idle("badop");

        // Inter-byte timeout: abort 16 cycles after the last accepted byte
        push(K_E, 8'h00, 8'h00);
        send_byte(8'h57); send_byte(8'h01);
        n = 0;
        while (!cmd_err && n < 100) begin
            @(posedge sysclk); #1;
            n++;
        end
        chk("tmo_latency", n, 16);
        wait_idle("timeout");
        chk("tmo_no_write", bank[1], 8'h01 ^ 8'h5C);
        do_read(8'h01);
        wait_idle("after_tmo");

        // Backpressure with stray bytes during the wait
        tx_busy = 1'b1;
        do_read(8'h04);
        tx0 = tx_cnt;
        for (int i = 0; i < 25; i++) begin
            send_byte((i % 2 == 0) ? 8'h33 : 8'h57);
            repeat (2) @(negedge sysclk);
        end
        chk("bp_no_tx", tx_cnt, tx0);
        chk("bp_busy", busy, 1);
        tx_busy = 1'b0;
        wait_idle("backpressure");
        repeat (10) @(negedge sysclk);
        chk("bp_one_tx", tx_cnt, tx0 + 1);

        // Reset in the middle of a write frame
        send_byte(8'h57); send_byte(8'h03);
        do_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_reg", uart_reg, 8'h00);
        push(K_E, 8'h00, 8'h00);
        push(K_T, 8'h00, 8'h45);
        send_byte(8'h5A);
        wait_idle("mid_reset");
        chk("mid_rst_no_write", bank[3], 8'h03 ^ 8'h5C);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
